uart_rx_ctrl: RTL and testbench

Sequencing controller for the uart_rx receiver. It arms the receiver with rx_start_o and drops the arm when the receiver acknowledges with clr_rx_start_bit_i. It captures each stored frame word into a small first-word-fall-through FIFO and tracks errors: overrun, frame timeout, and a saturating line-error count. It sits between uart_rx and the APB slave register file, which pops the FIFO and reads or clears the flags.

---
 rtl/uart_rx_ctrl_if.sv | 32 +++
 rtl/uart_rx_ctrl.sv | 141 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - uart_rx_ctrl receiver-side and register-side signal bundle
interface uart_rx_ctrl_if #(
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic          en;
  logic          rx_start_o;
  logic          clr_rx_start_bit_i;
  logic          store_i;
  logic [12:0]   rx_data_i;
  logic          rd_en;
  logic [9:0]    rd_data;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overrun;
  logic          timeout;
  logic [7:0]    err_cnt;
  logic          clr_err_i;
  logic          irq;

  modport master (
    output en, clr_rx_start_bit_i, store_i, rx_data_i, rd_en, clr_err_i,
    input  rx_start_o, rd_data, empty, full, count, overrun, timeout, err_cnt, irq
  );

  modport slave (
    input  en, clr_rx_start_bit_i, store_i, rx_data_i, rd_en, clr_err_i,
    output rx_start_o, rd_data, empty, full, count, overrun, timeout, err_cnt, irq
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - uart_rx arm/ack sequencer with FWFT receive FIFO and error tracking
module uart_rx_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 512
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_ctrl_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_BUSY} state_t;

  state_t        state, state_nxt;
  logic          rx_start_q;
  logic [15:0]   tmr;
  logic          capture, tmo_evt, tmr_clr;

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          fifo_empty, fifo_full, pop, push_ok, drop, err_inc;
  logic [9:0]    wdata;
  logic          overrun_q, timeout_q, irq_q;
  logic [7:0]    err_q;

  wire unused_rx_bits = &{1'b0, bus.rx_data_i[12:10]};

  // State register; rx_start is registered from the next state so it tracks ARM exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rx_start_q <= 1'b0;
      tmr        <= '0;
    end else begin
      state      <= state_nxt;
      rx_start_q <= (state_nxt == S_ARM);
      if (tmr_clr)
        tmr <= '0;
      else if (state == S_BUSY)
        tmr <= tmr + 16'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (bus.en) state_nxt = S_ARM;
      S_ARM: begin
        if (bus.store_i)
          state_nxt = bus.en ? S_ARM : S_IDLE;
        else if (!bus.en)
          state_nxt = S_IDLE;
        else if (bus.clr_rx_start_bit_i)
          state_nxt = S_BUSY;
      end
      S_BUSY: begin
        if (bus.store_i || tmr == TMO_LAST)
          state_nxt = bus.en ? S_ARM : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    capture = 1'b0;
    tmo_evt = 1'b0;
    tmr_clr = 1'b0;
    case (state)
      S_ARM: begin
        capture = bus.store_i;
        tmr_clr = bus.en && bus.clr_rx_start_bit_i && !bus.store_i;
      end
      S_BUSY: begin
        capture = bus.store_i;
        tmo_evt = !bus.store_i && (tmr == TMO_LAST);
      end
      default: ;
    endcase
  end

  assign fifo_empty = (cnt == '0);
  assign fifo_full  = (cnt == CW'(DEPTH));
  assign pop        = bus.rd_en && !fifo_empty;
  // A simultaneous pop frees a slot, so a push at full is still accepted.
  assign push_ok    = capture && (!fifo_full || pop);
  assign drop       = capture && fifo_full && !pop;
  assign wdata      = {bus.rx_data_i[9], bus.rx_data_i[8], bus.rx_data_i[7:0]};
  assign err_inc    = push_ok && (bus.rx_data_i[9] || bus.rx_data_i[8]);

  always_ff @(posedge clk) begin
    if (!rst && push_ok)
      mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Set events take priority over clr_err_i.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
      err_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      overrun_q <= drop    || (overrun_q && !bus.clr_err_i);
      timeout_q <= tmo_evt || (timeout_q && !bus.clr_err_i);
      if (bus.clr_err_i)
        err_q <= err_inc ? 8'd1 : 8'd0;
      else if (err_inc && err_q != 8'hFF)
        err_q <= err_q + 8'd1;
      irq_q <= !fifo_empty || overrun_q || timeout_q;
    end
  end

  assign bus.rx_start_o = rx_start_q;
  assign bus.rd_data    = fifo_empty ? 10'd0 : mem[rd_ptr];
  assign bus.empty      = fifo_empty;
  assign bus.full       = fifo_full;
  assign bus.count      = cnt;
  assign bus.overrun    = overrun_q;
  assign bus.timeout    = timeout_q;
  assign bus.err_cnt    = err_q;
  assign bus.irq        = irq_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl
module tb_uart_rx_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  uart_rx_ctrl_if #(.DEPTH(4)) bus ();

  uart_rx_ctrl #(.DEPTH(4), .TIMEOUT(512)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [12:0] d);
    bus.store_i   = 1'b1;
    bus.rx_data_i = d;
    tick();
    bus.store_i   = 1'b0;
    bus.rx_data_i = '0;
  endtask

  task automatic pop();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic ack();
    bus.clr_rx_start_bit_i = 1'b1;
    tick();
    bus.clr_rx_start_bit_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    fails++;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.en = 1'b0;
    bus.clr_rx_start_bit_i = 1'b0;
    bus.store_i = 1'b0;
    bus.rx_data_i = '0;
    bus.rd_en = 1'b0;
    bus.clr_err_i = 1'b0;
    tick();
    tick();
    chk("rst_rx_start", bus.rx_start_o, 0);
    chk("rst_empty",    bus.empty,      1);
    chk("rst_full",     bus.full,       0);
    chk("rst_count",    bus.count,      0);
    chk("rst_overrun",  bus.overrun,    0);
    chk("rst_timeout",  bus.timeout,    0);
    chk("rst_err_cnt",  bus.err_cnt,    0);
    chk("rst_irq",      bus.irq,        0);
    chk("rst_rd_data",  bus.rd_data,    0);

    rst = 1'b0;
    bus.en = 1'b1;
    tick();
    tick();
    chk("arm_after_rst", bus.rx_start_o, 1);
    ack();
    chk("ack_drops_arm", bus.rx_start_o, 0);
    store(13'h010);
    chk("first_rd_data", bus.rd_data,    10'h010);
    chk("first_empty",   bus.empty,      0);
    chk("first_count",   bus.count,      1);
    chk("first_rearm",   bus.rx_start_o, 1);
    tick();
    chk("first_irq",     bus.irq,        1);
    pop();
    chk("pop_empty",     bus.empty,      1);

    store(13'h2A5);
    chk("fe_rd_data",    bus.rd_data,    10'h2A5);
    chk("fe_err_cnt",    bus.err_cnt,    1);
    bus.clr_err_i = 1'b1;
    store(13'h1FF);
    bus.clr_err_i = 1'b0;
    chk("clr_vs_pe_err_cnt", bus.err_cnt, 1);
    bus.clr_err_i = 1'b1;
    tick();
    bus.clr_err_i = 1'b0;
    chk("clr_err_cnt",   bus.err_cnt,    0);
    chk("clr_overrun",   bus.overrun,    0);
    chk("clr_timeout",   bus.timeout,    0);
    chk("head_2a5",      bus.rd_data,    10'h2A5);
    pop();
    chk("head_1ff",      bus.rd_data,    10'h1FF);
    pop();
    store(13'h1C33);
    chk("ignored_bits",  bus.rd_data,    10'h033);
    chk("ignored_err",   bus.err_cnt,    0);
    pop();

    for (int i = 1; i <= 5; i++) begin
      store(13'(i));
      if (i == 4) begin
        chk("full_after_4",    bus.full,    1);
        chk("no_overrun_4",    bus.overrun, 0);
      end
    end
    chk("overrun_after_5", bus.overrun, 1);
    chk("count_after_5",   bus.count,   4);
    for (int i = 1; i <= 4; i++) begin
      chk("order_pop", bus.rd_data, 32'(i));
      pop();
    end
    chk("drained_empty",   bus.empty,   1);
    chk("drained_rd_data", bus.rd_data, 0);
    bus.clr_err_i = 1'b1;
    tick();
    bus.clr_err_i = 1'b0;
    chk("overrun_cleared", bus.overrun, 0);

    for (int i = 1; i <= 4; i++) store(13'(8'h10 + i));
    chk("refill_full", bus.full, 1);
    bus.rd_en = 1'b1;
    store(13'h015);
    bus.rd_en = 1'b0;
    chk("pushpop_count",   bus.count,   4);
    chk("pushpop_overrun", bus.overrun, 0);
    for (int i = 2; i <= 5; i++) begin
      chk("pushpop_order", bus.rd_data, 32'(8'h10 + i));
      pop();
    end
    chk("pushpop_empty", bus.empty, 1);

    ack();
    repeat (511) tick();
    chk("pre_timeout",       bus.timeout,    0);
    chk("pre_timeout_arm",   bus.rx_start_o, 0);
    tick();
    chk("timeout_set",       bus.timeout,    1);
    chk("timeout_rearm",     bus.rx_start_o, 1);
    tick();
    chk("timeout_irq",       bus.irq,        1);
    bus.clr_err_i = 1'b1;
    tick();
    bus.clr_err_i = 1'b0;
    chk("timeout_cleared",   bus.timeout,    0);

    ack();
    repeat (511) tick();
    store(13'h07E);
    chk("late_store_timeout", bus.timeout,    0);
    chk("late_store_data",    bus.rd_data,    10'h07E);
    chk("late_store_rearm",   bus.rx_start_o, 1);
    pop();

    ack();
    bus.en = 1'b0;
    tick();
    chk("en_off_busy_arm",  bus.rx_start_o, 0);
    store(13'h055);
    chk("en_off_data",      bus.rd_data,    10'h055);
    chk("en_off_count",     bus.count,      1);
    chk("en_off_idle",      bus.rx_start_o, 0);
    store(13'h0AA);
    chk("idle_store_count", bus.count,      1);
    bus.en = 1'b1;
    tick();
    store(13'h066);
    chk("count_two",        bus.count,      2);
    ack();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.en = 1'b0;
    chk("midrst_count",     bus.count,      0);
    chk("midrst_empty",     bus.empty,      1);
    chk("midrst_rx_start",  bus.rx_start_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
